// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential unsigned multiply/divide sharing an external adder
// 32 single-bit iterations per operation; the adder is driven combinationally from registers.
module muldiv_seq #(
  parameter int W    = 32,
  parameter int CNTW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op,
  input  logic [W-1:0]  opa,
  input  logic [W-1:0]  opb,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  res_hi,
  output logic [W-1:0]  res_lo,
  output logic          dz,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  output logic          add_sub,
  input  logic [W-1:0]  add_sum,
  input  logic          add_cout
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            op_r;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;
  logic [W-1:0]    hi_nxt;
  logic [W-1:0]    lo_nxt;
  logic [W-1:0]    rem_sh;
  logic            q;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    hi_nxt  = hi;
    lo_nxt  = lo;
    rem_sh  = {hi[W-2:0], lo[W-1]};
    q       = 1'b0;
    if (state == CALC) begin
      if (!op_r) begin
        add_a  = hi;
        add_b  = lo[0] ? b_reg : '0;
        hi_nxt = {add_cout, add_sum[W-1:1]};
        lo_nxt = {add_sum[0], lo[W-1:1]};
      end else begin
        // A set msb means the shifted remainder already exceeds any divisor; sum wraps correctly.
        add_a   = rem_sh;
        add_b   = b_reg;
        add_sub = 1'b1;
        q       = hi[W-1] | add_cout;
        hi_nxt  = q ? add_sum : rem_sh;
        lo_nxt  = {lo[W-2:0], q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= 1'b0;
      b_reg  <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      dz     <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(W-1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            res_hi <= hi_nxt;
            res_lo <= lo_nxt;
            dz     <= op_r && (b_reg == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept, so a start in the done cycle chains directly.
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            op_r  <= op;
            b_reg <= opb;
            hi    <= '0;
            lo    <= opa;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed checks of muldiv_seq against an arithmetic model
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy, done, dz, add_sub, add_cout;
  logic [31:0] res_hi, res_lo, add_a, add_b, add_sum;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.W(32), .CNTW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .dz(dz),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // External adder: a + ~b + 1 when subtracting, carry out means no borrow.
  logic [32:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + {32'b0, add_sub};
  assign add_sum  = add_full[31:0];
  assign add_cout = add_full[32];

  // Reference: count 32 busy cycles after accept, then one done cycle with arithmetic results.
  logic        m_busy, m_done, m_op, m_dz;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  int          m_left;
  logic [63:0] m_prod;
  assign m_prod = {32'b0, m_a} * {32'b0, m_b};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_op <= 1'b0; m_dz <= 1'b0;
      m_a <= '0; m_b <= '0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (start && !m_busy) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_left <= 32;
      m_op <= op; m_a <= opa; m_b <= opb;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dz   <= m_op && (m_b == 0);
        if (!m_op) begin
          m_hi <= m_prod[63:32];
          m_lo <= m_prod[31:0];
        end else if (m_b == 0) begin
          m_hi <= m_a;
          m_lo <= 32'hFFFFFFFF;
        end else begin
          m_hi <= m_a % m_b;
          m_lo <= m_a / m_b;
        end
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("res_hi", res_hi, m_hi);
    chk("res_lo", res_lo, m_lo);
    chk("dz", 32'(dz), 32'(m_dz));
    if (m_busy) begin
      chk("add_sub_calc", 32'(add_sub), 32'(m_op));
    end else begin
      chk("add_a_idle", add_a, 32'h0);
      chk("add_b_idle", add_b, 32'h0);
      chk("add_sub_idle", 32'(add_sub), 32'h0);
    end
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, output int lat);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; op = $urandom_range(0, 1); opa = $urandom; opb = $urandom;
    wait_done(lat);
  endtask

  int lat;
  logic [31:0] ra, rb;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_res_hi", res_hi, 32'h0);
    chk("rst_add_a", add_a, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("mul_ff_lat", 32'(lat), 32'd33);
    chk("mul_ff_hi", res_hi, 32'hFFFFFFFE);
    chk("mul_ff_lo", res_lo, 32'h00000001);
    chk("mul_ff_dz", 32'(dz), 32'h0);

    run_op(1'b1, 32'd100, 32'd7, lat);
    chk("div_100_7_q", res_lo, 32'd14);
    chk("div_100_7_r", res_hi, 32'd2);

    run_op(1'b1, 32'hFFFFFFFF, 32'h80000000, lat);
    chk("div_msb_q", res_lo, 32'd1);
    chk("div_msb_r", res_hi, 32'h7FFFFFFF);

    run_op(1'b1, 32'd5, 32'd9, lat);
    chk("div_5_9_q", res_lo, 32'd0);
    chk("div_5_9_r", res_hi, 32'd5);

    run_op(1'b1, 32'h00001234, 32'h0, lat);
    chk("dz_lat", 32'(lat), 32'd33);
    chk("dz_q", res_lo, 32'hFFFFFFFF);
    chk("dz_r", res_hi, 32'h00001234);
    chk("dz_flag", 32'(dz), 32'h1);

    // Start while busy is ignored; start during done chains back-to-back.
    start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'd7; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_lo", res_lo, 32'd15);
    chk("ign_hi", res_hi, 32'd0);
    start = 1'b1; op = 1'b1; opa = 32'd9; opb = 32'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_hold", res_lo, 32'd15);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_q", res_lo, 32'd4);
    chk("b2b_r", res_hi, 32'd1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'h1234; opb = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_res_hi", res_hi, 32'h0);
    chk("arst_res_lo", res_lo, 32'h0);
    chk("arst_dz", 32'(dz), 32'h0);
    chk("arst_add_a", add_a, 32'h0);
    chk("arst_add_b", add_b, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_done_res", res_lo, 32'h0);
    run_op(1'b0, 32'd6, 32'd7, lat);
    chk("after_rst_lo", res_lo, 32'd42);
    chk("after_rst_hi", res_hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      run_op(1'($urandom_range(0, 1)), ra, rb, lat);
      chk("rand_lat", 32'(lat), 32'd33);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
